trap_ctrl: RTL and testbench

Machine-mode trap sequencer between the commit stage and the CSR file. It detects ecall, mret and pending machine-timer interrupts at commit. It then drives the CSR file's trap write ports for mepc, mcause and mstatus in a fixed multi-cycle sequence, and redirects fetch to the trap vector or the return address. While a sequence is in flight it holds the pipeline, so no CPU CSR write competes with its writes.

---
 rtl/trap_ctrl_pkg.sv | 19 +
 rtl/trap_ctrl_target_calc.sv | 42 ++++
 rtl/trap_ctrl.sv | 143 ++++++++++++++
 tb/tb_trap_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SAVE  = 2'd1,
      ST_MSTAT = 2'd2,
      ST_JUMP  = 2'd3
   } trap_state_e;

   localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
   localparam logic [63:0] CAUSE_MTIMER  = 64'h8000_0000_0000_0007;

   localparam int unsigned MSTATUS_MIE    = 3;
   localparam int unsigned MSTATUS_MPIE   = 7;
   localparam int unsigned MSTATUS_MPP_LO = 11;
   localparam int unsigned MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/trap_ctrl_target_calc.sv
// Redirect target selection: mret return address, direct trap base, or
// vectored interrupt entry when CLINT_VECTORED_EN is defined.
module trap_target_calc
   import trap_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   input  logic [XLEN-1:0] cause,
   input  logic            is_mret,
   output logic [XLEN-1:0] target
);

   logic [XLEN-1:0] base;

   assign base = {mtvec[XLEN-1:2], 2'b00};

`ifdef CLINT_VECTORED_EN
   always_comb begin
      target = base;
      if (is_mret) begin
         target = mepc;
      end else if (mtvec[1:0] == 2'b01 && cause[XLEN-1]) begin
         // Interrupts only; synchronous exceptions always enter at base.
         target = base + {cause[XLEN-3:0], 2'b00};
      end
   end
`else
   logic unused_cfg;

   assign unused_cfg = ^{mtvec[1:0], cause};

   always_comb begin
      target = base;
      if (is_mret) begin
         target = mepc;
      end
   end
`endif

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: ecall / mret / timer interrupt at commit,
// CSR write sequencing and fetch redirect. Optional: CLINT_VECTORED_EN.
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inst_valid_i,
   input  logic [XLEN-1:0] inst_pc_i,
   input  logic            inst_ecall_i,
   input  logic            inst_mret_i,
   input  logic [XLEN-1:0] csr_mtvec_i,
   input  logic [XLEN-1:0] csr_mepc_i,
   input  logic [XLEN-1:0] csr_mstatus_i,
   input  logic            global_int_en_i,
   input  logic            mtime_int_en_i,
   input  logic            mtime_int_pend_i,
   output logic            mepc_wen_o,
   output logic [XLEN-1:0] mepc_wdata_o,
   output logic            mcause_wen_o,
   output logic [XLEN-1:0] mcause_wdata_o,
   output logic            mstatus_wen_o,
   output logic [XLEN-1:0] mstatus_wdata_o,
   output logic            hold_o,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o
);

   trap_state_e     state_q, state_d;
   logic            commit;
   logic            take_int, take_ecall, take_mret, take_any;
   logic [XLEN-1:0] pc_q, cause_q, target_q, target_d;
   logic            mret_q;
   logic [XLEN-1:0] mstatus_new;

   // Event decode; gated by rst_n so a held reset never raises hold_o.
   always_comb begin
      commit     = rst_n & (state_q == ST_IDLE) & inst_valid_i;
      take_int   = commit & global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
      take_ecall = commit & inst_ecall_i & ~take_int;
      take_mret  = commit & inst_mret_i & ~take_int & ~inst_ecall_i;
      take_any   = take_int | take_ecall | take_mret;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (take_int || take_ecall) begin
               state_d = ST_SAVE;
            end else if (take_mret) begin
               state_d = ST_MSTAT;
            end
         end
         ST_SAVE:  state_d = ST_MSTAT;
         ST_MSTAT: state_d = ST_JUMP;
         ST_JUMP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q     <= '0;
         cause_q  <= '0;
         mret_q   <= 1'b0;
         target_q <= '0;
      end else begin
         if (take_any) begin
            pc_q    <= inst_pc_i;
            mret_q  <= take_mret;
            cause_q <= take_int ? XLEN'(CAUSE_MTIMER) : XLEN'(CAUSE_ECALL_M);
         end
         // mepc for mret is sampled here, one cycle before the redirect.
         if (state_q == ST_MSTAT) begin
            target_q <= target_d;
         end
      end
   end

   trap_target_calc #(
      .XLEN (XLEN)
   ) u_target (
      .mtvec   (csr_mtvec_i),
      .mepc    (csr_mepc_i),
      .cause   (cause_q),
      .is_mret (mret_q),
      .target  (target_d)
   );

   always_comb begin
      mstatus_new = csr_mstatus_i;
      if (mret_q) begin
         mstatus_new[MSTATUS_MIE]  = csr_mstatus_i[MSTATUS_MPIE];
         mstatus_new[MSTATUS_MPIE] = 1'b1;
      end else begin
         mstatus_new[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
         mstatus_new[MSTATUS_MIE]  = 1'b0;
      end
      mstatus_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
   end

   // Data outputs are forced to zero whenever their strobe is low.
   always_comb begin
      hold_o           = (state_q != ST_IDLE) | take_any;
      mepc_wen_o       = 1'b0;
      mepc_wdata_o     = '0;
      mcause_wen_o     = 1'b0;
      mcause_wdata_o   = '0;
      mstatus_wen_o    = 1'b0;
      mstatus_wdata_o  = '0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      unique case (state_q)
         ST_SAVE: begin
            mepc_wen_o     = 1'b1;
            mepc_wdata_o   = pc_q;
            mcause_wen_o   = 1'b1;
            mcause_wdata_o = cause_q;
         end
         ST_MSTAT: begin
            mstatus_wen_o   = 1'b1;
            mstatus_wdata_o = mstatus_new;
         end
         ST_JUMP: begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = target_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed vector table, reset-abort
// sequence, and randomized traffic against a schedule-based reference model.
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inst_valid_i, inst_ecall_i, inst_mret_i;
   logic [63:0] inst_pc_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
   logic        global_int_en_i, mtime_int_en_i, mtime_int_pend_i;
   logic        mepc_wen_o, mcause_wen_o, mstatus_wen_o, hold_o, redirect_valid_o;
   logic [63:0] mepc_wdata_o, mcause_wdata_o, mstatus_wdata_o, redirect_pc_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   trap_ctrl #(.XLEN(64)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .inst_valid_i     (inst_valid_i),
      .inst_pc_i        (inst_pc_i),
      .inst_ecall_i     (inst_ecall_i),
      .inst_mret_i      (inst_mret_i),
      .csr_mtvec_i      (csr_mtvec_i),
      .csr_mepc_i       (csr_mepc_i),
      .csr_mstatus_i    (csr_mstatus_i),
      .global_int_en_i  (global_int_en_i),
      .mtime_int_en_i   (mtime_int_en_i),
      .mtime_int_pend_i (mtime_int_pend_i),
      .mepc_wen_o       (mepc_wen_o),
      .mepc_wdata_o     (mepc_wdata_o),
      .mcause_wen_o     (mcause_wen_o),
      .mcause_wdata_o   (mcause_wdata_o),
      .mstatus_wen_o    (mstatus_wen_o),
      .mstatus_wdata_o  (mstatus_wdata_o),
      .hold_o           (hold_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o)
   );

   typedef struct {
      string       name;
      logic        valid, ecall, mret, gie, mtie, mtip;
      logic [63:0] pc, mstatus, mtvec, mepc;
      logic        exp_evt, exp_mret;
      logic [63:0] exp_cause, exp_mstatus, exp_target;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] ctl_bits();
      return {59'd0, hold_o, mepc_wen_o, mcause_wen_o, mstatus_wen_o, redirect_valid_o};
   endfunction

   // {hold, mepc_wen, mcause_wen, mstatus_wen, redirect_valid}
   function automatic logic [63:0] ctl(input logic h, input logic a, input logic b,
                                       input logic c, input logic d);
      return {59'd0, h, a, b, c, d};
   endfunction

   // Architectural mstatus rules written as masks.
   function automatic logic [63:0] ref_trap_ms(input logic [63:0] ms);
      return (ms & ~64'h1888) | 64'h1800 | (ms[3] ? 64'h80 : 64'h0);
   endfunction

   function automatic logic [63:0] ref_mret_ms(input logic [63:0] ms);
      return (ms & ~64'h1888) | 64'h1880 | (ms[7] ? 64'h8 : 64'h0);
   endfunction

   function automatic logic [63:0] ref_trap_tgt(input logic [63:0] mtvec, input logic is_int);
      logic [63:0] base;
      base = mtvec & ~64'h3;
`ifdef CLINT_VECTORED_EN
      if (is_int && mtvec[1:0] == 2'b01) base = base + 64'd4 * 64'd7;
`endif
      return base;
   endfunction

   function automatic vec_t mk(input string name, input logic valid, input logic ecall,
                               input logic mret, input logic gie, input logic mtie,
                               input logic mtip, input logic [63:0] pc,
                               input logic [63:0] ms, input logic [63:0] mtvec,
                               input logic [63:0] mepc, input logic exp_evt,
                               input logic exp_mret, input logic [63:0] exp_cause,
                               input logic [63:0] exp_ms, input logic [63:0] exp_tgt);
      vec_t v;
      v.name = name; v.valid = valid; v.ecall = ecall; v.mret = mret;
      v.gie = gie; v.mtie = mtie; v.mtip = mtip; v.pc = pc; v.mstatus = ms;
      v.mtvec = mtvec; v.mepc = mepc; v.exp_evt = exp_evt; v.exp_mret = exp_mret;
      v.exp_cause = exp_cause; v.exp_mstatus = exp_ms; v.exp_target = exp_tgt;
      return v;
   endfunction

   task automatic idle_inputs();
      inst_valid_i = 0; inst_ecall_i = 0; inst_mret_i = 0; inst_pc_i = '0;
      csr_mtvec_i = '0; csr_mepc_i = '0; csr_mstatus_i = '0;
      global_int_en_i = 0; mtime_int_en_i = 0; mtime_int_pend_i = 0;
   endtask

   task automatic run_vec(input vec_t v);
      int stage;
      @(negedge clk);
      inst_valid_i = v.valid; inst_ecall_i = v.ecall; inst_mret_i = v.mret;
      global_int_en_i = v.gie; mtime_int_en_i = v.mtie; mtime_int_pend_i = v.mtip;
      inst_pc_i = v.pc; csr_mstatus_i = v.mstatus; csr_mtvec_i = v.mtvec; csr_mepc_i = v.mepc;
      #1;
      chk({v.name, " ctl@T"}, ctl_bits(), ctl(v.exp_evt, 0, 0, 0, 0));
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         inst_valid_i = 0; inst_ecall_i = 0; inst_mret_i = 0;
         #1;
         // stage: 0 idle, 1 save, 2 mstatus, 3 jump
         stage = 0;
         if (v.exp_evt) stage = v.exp_mret ? ((c <= 2) ? c + 1 : 0) : ((c <= 3) ? c : 0);
         chk($sformatf("%s ctl@T+%0d", v.name, c), ctl_bits(),
             ctl(stage != 0, stage == 1, stage == 1, stage == 2, stage == 3));
         if (stage == 1) begin
            chk({v.name, " mepc"}, mepc_wdata_o, v.pc);
            chk({v.name, " mcause"}, mcause_wdata_o, v.exp_cause);
         end
         if (stage == 2) chk({v.name, " mstatus"}, mstatus_wdata_o, v.exp_mstatus);
         if (stage == 3) chk({v.name, " target"}, redirect_pc_o, v.exp_target);
      end
   endtask

   // Reference model: a schedule of pending actions (1 write mepc/mcause,
   // 2 write mstatus, 3 redirect) queued when an event is accepted.
   int          sched[$];
   logic [63:0] m_pc, m_cause, m_target;
   logic        m_mret, m_int;

   task automatic rand_cycle();
      logic is_int, ev;
      int act;
      @(negedge clk);
      rst_n            = ($urandom_range(0, 59) != 0);
      inst_valid_i     = ($urandom_range(0, 9) < 6);
      inst_ecall_i     = ($urandom_range(0, 3) == 0);
      inst_mret_i      = ($urandom_range(0, 3) == 0);
      global_int_en_i  = $urandom_range(0, 1);
      mtime_int_en_i   = $urandom_range(0, 1);
      mtime_int_pend_i = $urandom_range(0, 1);
      inst_pc_i        = {$urandom, $urandom};
      csr_mtvec_i      = {$urandom, $urandom};
      csr_mepc_i       = {$urandom, $urandom};
      csr_mstatus_i    = {$urandom, $urandom};
      #1;
      is_int = global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
      ev = rst_n && sched.size() == 0 && inst_valid_i && (is_int || inst_ecall_i || inst_mret_i);
      act = (sched.size() != 0) ? sched[0] : 0;
      chk("rand ctl", ctl_bits(),
          ctl(sched.size() != 0 || ev, act == 1, act == 1, act == 2, act == 3));
      if (act == 1) begin
         chk("rand mepc", mepc_wdata_o, m_pc);
         chk("rand mcause", mcause_wdata_o, m_cause);
      end
      if (act == 2)
         chk("rand mstatus", mstatus_wdata_o,
             m_mret ? ref_mret_ms(csr_mstatus_i) : ref_trap_ms(csr_mstatus_i));
      if (act == 3) chk("rand target", redirect_pc_o, m_target);
      if (sched.size() != 0) begin
         if (act == 2) m_target = m_mret ? csr_mepc_i : ref_trap_tgt(csr_mtvec_i, m_int);
         void'(sched.pop_front());
      end else if (ev) begin
         m_pc    = inst_pc_i;
         m_int   = is_int;
         m_mret  = !is_int && !inst_ecall_i;
         m_cause = is_int ? 64'h8000_0000_0000_0007 : 64'd11;
         if (m_mret) sched = '{2, 3};
         else sched = '{1, 2, 3};
      end
      if (!rst_n) sched.delete();
   endtask

   initial begin
      logic [63:0] vec_tgt;
`ifdef CLINT_VECTORED_EN
      vec_tgt = 64'h8000_101C;
`else
      vec_tgt = 64'h8000_1000;
`endif
      vecs[0] = mk("ecall", 1, 1, 0, 0, 0, 0, 64'h8000_0010, 64'h1888, 64'h8000_1000, 64'h0,
                   1, 0, 64'd11, 64'h1880, 64'h8000_1000);
      vecs[1] = mk("int_over_ecall", 1, 1, 0, 1, 1, 1, 64'h8000_0020, 64'h0008, 64'h8000_1000, 64'h0,
                   1, 0, 64'h8000_0000_0000_0007, 64'h1880, 64'h8000_1000);
      vecs[2] = mk("mret", 1, 0, 1, 0, 0, 0, 64'h8000_0030, 64'h1880, 64'h8000_1000, 64'h8000_0014,
                   1, 1, 64'h0, 64'h1888, 64'h8000_0014);
      vecs[3] = mk("timer_vectored", 1, 0, 0, 1, 1, 1, 64'h8000_0040, 64'h0008, 64'h8000_1001, 64'h0,
                   1, 0, 64'h8000_0000_0000_0007, 64'h1880, vec_tgt);
      vecs[4] = mk("mtip_mie0", 1, 0, 0, 0, 1, 1, 64'h8000_0050, 64'h0000, 64'h8000_1000, 64'h0,
                   0, 0, 64'h0, 64'h0, 64'h0);
      vecs[5] = mk("mtip_novalid", 0, 0, 0, 1, 1, 1, 64'h8000_0060, 64'h0008, 64'h8000_1000, 64'h0,
                   0, 0, 64'h0, 64'h0, 64'h0);
      vecs[6] = mk("ecall_over_mret", 1, 1, 1, 0, 0, 0, 64'h8000_0070, 64'h1888, 64'h8000_1000, 64'h1234,
                   1, 0, 64'd11, 64'h1880, 64'h8000_1000);
      vecs[7] = mk("ecall_passthru", 1, 1, 0, 0, 0, 0, 64'h8000_0080, 64'hF0F0_0000_0000_0008,
                   64'h8000_2003, 64'h0, 1, 0, 64'd11, 64'hF0F0_0000_0000_1880, 64'h8000_2000);

      idle_inputs();
      rst_n = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset ctl", ctl_bits(), 64'h0);
      chk("reset data", mepc_wdata_o | mcause_wdata_o | mstatus_wdata_o | redirect_pc_o, 64'h0);
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Reset asserted while in SAVE aborts the sequence.
      @(negedge clk);
      inst_valid_i = 1; inst_ecall_i = 1; inst_pc_i = 64'h8000_0090;
      csr_mstatus_i = 64'h1888; csr_mtvec_i = 64'h8000_1000;
      @(negedge clk);
      idle_inputs();
      rst_n = 0;
      #1;
      chk("abort in save", ctl_bits(), ctl(1, 1, 1, 0, 0));
      @(negedge clk);
      #1;
      chk("abort ctl", ctl_bits(), 64'h0);
      chk("abort data", mepc_wdata_o | mcause_wdata_o | mstatus_wdata_o | redirect_pc_o, 64'h0);
      rst_n = 1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         chk("abort quiet", ctl_bits(), 64'h0);
      end

      sched.delete();
      for (int i = 0; i < 1500; i++) rand_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
